// File: rtl/treeval_cmd_engine.sv
// rtl/treeval_cmd_engine.sv - multi-unit command engine for the treeval accelerator
// Optional completion watchdog on blocking runs: define TREEVAL_CMD_TIMEOUT_EN.
module treeval_cmd_engine #(
  parameter int N_UNITS  = 2,
  parameter int W_ADDR   = 10,
  parameter int W_DATA   = 10,
  parameter int W_REWARD = 10,
  parameter int W_ACTION = 3,
  parameter int TIMEOUT  = 1023
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_msg_rdy,
  input  logic [63:0]                    in_msg,
  output logic                           in_msg_ack,
  output logic                           out_msg_rdy,
  output logic [63:0]                    out_msg,
  input  logic                           out_msg_ack,
  output logic [N_UNITS-1:0]             eu_start,
  output logic [N_UNITS-1:0]             eu_mem_wr,
  output logic [1:0]                     eu_mem_field,
  output logic [W_ADDR-1:0]              eu_mem_addr,
  output logic [W_DATA-1:0]              eu_mem_data,
  output logic [N_UNITS-1:0]             eu_conf_wr,
  output logic [W_DATA-1:0]              eu_conf_data,
  input  logic [N_UNITS-1:0]             eu_done,
  input  logic [N_UNITS*W_REWARD-1:0]    eu_exp,
  input  logic [N_UNITS*W_ACTION-1:0]    eu_act
);
  localparam int W_RES = W_ACTION + W_REWARD;
  localparam logic [1:0] CMD_RUN = 2'd0, CMD_NODE = 2'd1, CMD_CONF = 2'd2, CMD_QUERY = 2'd3;
  localparam logic [1:0] RSP_RESULT = 2'd0, RSP_ERROR = 2'd1, RSP_STATUS = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [63:0]        msg_q, msg_d;
  logic               in_msg_ack_q, in_msg_ack_d;
  logic               out_msg_rdy_q, out_msg_rdy_d;
  logic [63:0]        out_msg_q, out_msg_d;
  logic [N_UNITS-1:0] eu_start_q, eu_start_d;
  logic [N_UNITS-1:0] eu_mem_wr_q, eu_mem_wr_d;
  logic [1:0]         eu_mem_field_q, eu_mem_field_d;
  logic [W_ADDR-1:0]  eu_mem_addr_q, eu_mem_addr_d;
  logic [W_DATA-1:0]  eu_mem_data_q, eu_mem_data_d;
  logic [N_UNITS-1:0] eu_conf_wr_q, eu_conf_wr_d;
  logic [W_DATA-1:0]  eu_conf_data_q, eu_conf_data_d;
  logic [N_UNITS-1:0] sticky_q, sticky_d;
  logic [W_RES-1:0]   res_q [N_UNITS];
  logic [W_RES-1:0]   res_d [N_UNITS];
  logic               armed_q, armed_d;
  logic [N_UNITS-1:0] wait_clr_q, wait_clr_d;
`ifdef TREEVAL_CMD_TIMEOUT_EN
  localparam int W_CNT = $clog2(TIMEOUT + 1);
  logic [W_CNT-1:0]   cnt_q, cnt_d;
`endif

  logic [1:0]         cmd, sub;
  logic [3:0]         uid;
  logic [N_UNITS-1:0] uoh, sticky_clr;
  logic               uid_ok, sel_done, sel_sticky;
  logic [W_RES-1:0]   sel_live, sel_res;
  logic               resp_vld;
  logic [1:0]         resp_type;
  logic [55:0]        resp_pl;
  logic               unused_msg;

  assign unused_msg = ^msg_q[55:0];

  // Per-unit selection by a loop compare so out-of-range ids simply select nothing.
  always_comb begin
    cmd        = msg_q[63:62];
    sub        = msg_q[61:60];
    uid        = msg_q[59:56];
    uoh        = '0;
    sel_done   = 1'b0;
    sel_sticky = 1'b0;
    sel_live   = '0;
    sel_res    = '0;
    for (int i = 0; i < N_UNITS; i++) begin
      if (uid == 4'(i)) begin
        uoh[i]     = 1'b1;
        sel_done   = eu_done[i];
        sel_sticky = sticky_q[i];
        sel_live   = {eu_act[i*W_ACTION +: W_ACTION], eu_exp[i*W_REWARD +: W_REWARD]};
        sel_res    = res_q[i];
      end
    end
    uid_ok = |uoh;
  end

  always_comb begin
    state_d        = state_q;
    msg_d          = msg_q;
    in_msg_ack_d   = 1'b0;
    out_msg_rdy_d  = out_msg_rdy_q;
    out_msg_d      = out_msg_q;
    eu_start_d     = '0;
    eu_mem_wr_d    = '0;
    eu_conf_wr_d   = '0;
    eu_mem_field_d = eu_mem_field_q;
    eu_mem_addr_d  = eu_mem_addr_q;
    eu_mem_data_d  = eu_mem_data_q;
    eu_conf_data_d = eu_conf_data_q;
    armed_d        = armed_q;
    wait_clr_d     = '0;
    sticky_clr     = '0;
    resp_vld       = 1'b0;
    resp_type      = RSP_ERROR;
    resp_pl        = '0;
`ifdef TREEVAL_CMD_TIMEOUT_EN
    cnt_d          = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_msg_rdy && !in_msg_ack_q) begin
          msg_d        = in_msg;
          in_msg_ack_d = 1'b1;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (cmd)
          CMD_NODE: begin
            if (!uid_ok) begin resp_vld = 1'b1; resp_pl = 56'd1; end
            else begin
              eu_mem_wr_d    = uoh;
              eu_mem_field_d = sub;
              eu_mem_addr_d  = msg_q[W_ADDR+W_DATA-1:W_DATA];
              eu_mem_data_d  = msg_q[W_DATA-1:0];
            end
          end
          CMD_CONF: begin
            if (sub != 2'd0)  begin resp_vld = 1'b1; resp_pl = 56'd3; end
            else if (!uid_ok) begin resp_vld = 1'b1; resp_pl = 56'd1; end
            else begin
              eu_conf_wr_d   = uoh;
              eu_conf_data_d = msg_q[W_DATA-1:0];
            end
          end
          CMD_RUN: begin
            if (sub[1])       begin resp_vld = 1'b1; resp_pl = 56'd3; end
            else if (!uid_ok) begin resp_vld = 1'b1; resp_pl = 56'd1; end
            else begin
              eu_start_d = uoh;
              sticky_clr = uoh;
              if (sub == 2'd0) begin
                state_d = S_WAIT;
                armed_d = 1'b0;
`ifdef TREEVAL_CMD_TIMEOUT_EN
                cnt_d   = '0;
`endif
              end
            end
          end
          default: begin
            if (sub == 2'd0) begin
              resp_vld = 1'b1; resp_type = RSP_STATUS; resp_pl = 56'(sticky_q);
            end else if (sub == 2'd1) begin
              if (!uid_ok)         begin resp_vld = 1'b1; resp_pl = 56'd1; end
              else if (sel_sticky) begin
                resp_vld = 1'b1; resp_type = RSP_RESULT; resp_pl = 56'(sel_res);
                sticky_clr = uoh;
              end else             begin resp_vld = 1'b1; resp_pl = 56'd4; end
            end else begin
              resp_vld = 1'b1; resp_pl = 56'd3;
            end
          end
        endcase
      end
      S_WAIT: begin
        // The start pulse cycle itself is not sampled; armed_q opens the window a cycle later.
        armed_d = 1'b1;
        if (armed_q && sel_done) begin
          resp_vld = 1'b1; resp_type = RSP_RESULT; resp_pl = 56'(sel_live);
          wait_clr_d = uoh;
        end
`ifdef TREEVAL_CMD_TIMEOUT_EN
        else if (cnt_q == W_CNT'(TIMEOUT - 1)) begin
          resp_vld = 1'b1; resp_pl = 56'd2;
        end
        cnt_d = cnt_q + W_CNT'(1);
`endif
      end
      default: begin
        if (out_msg_ack && out_msg_rdy_q) begin
          out_msg_rdy_d = 1'b0;
          out_msg_d     = '0;
          state_d       = S_IDLE;
        end
      end
    endcase
    if (resp_vld) begin
      out_msg_rdy_d = 1'b1;
      out_msg_d     = {resp_type, 2'b00, uid, resp_pl};
      state_d       = S_RESP;
    end
    // Blocking-run clear is delayed one cycle so it lands after the done that set the bit.
    sticky_d = (sticky_q & ~sticky_clr & ~wait_clr_q) | eu_done;
    for (int i = 0; i < N_UNITS; i++) begin
      res_d[i] = eu_done[i] ? {eu_act[i*W_ACTION +: W_ACTION], eu_exp[i*W_REWARD +: W_REWARD]}
                            : res_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      msg_q          <= '0;
      in_msg_ack_q   <= 1'b0;
      out_msg_rdy_q  <= 1'b0;
      out_msg_q      <= '0;
      eu_start_q     <= '0;
      eu_mem_wr_q    <= '0;
      eu_mem_field_q <= '0;
      eu_mem_addr_q  <= '0;
      eu_mem_data_q  <= '0;
      eu_conf_wr_q   <= '0;
      eu_conf_data_q <= '0;
      sticky_q       <= '0;
      armed_q        <= 1'b0;
      wait_clr_q     <= '0;
      for (int i = 0; i < N_UNITS; i++) res_q[i] <= '0;
`ifdef TREEVAL_CMD_TIMEOUT_EN
      cnt_q          <= '0;
`endif
    end else begin
      state_q        <= state_d;
      msg_q          <= msg_d;
      in_msg_ack_q   <= in_msg_ack_d;
      out_msg_rdy_q  <= out_msg_rdy_d;
      out_msg_q      <= out_msg_d;
      eu_start_q     <= eu_start_d;
      eu_mem_wr_q    <= eu_mem_wr_d;
      eu_mem_field_q <= eu_mem_field_d;
      eu_mem_addr_q  <= eu_mem_addr_d;
      eu_mem_data_q  <= eu_mem_data_d;
      eu_conf_wr_q   <= eu_conf_wr_d;
      eu_conf_data_q <= eu_conf_data_d;
      sticky_q       <= sticky_d;
      armed_q        <= armed_d;
      wait_clr_q     <= wait_clr_d;
      for (int i = 0; i < N_UNITS; i++) res_q[i] <= res_d[i];
`ifdef TREEVAL_CMD_TIMEOUT_EN
      cnt_q          <= cnt_d;
`endif
    end
  end

  assign in_msg_ack   = in_msg_ack_q;
  assign out_msg_rdy  = out_msg_rdy_q;
  assign out_msg      = out_msg_q;
  assign eu_start     = eu_start_q;
  assign eu_mem_wr    = eu_mem_wr_q;
  assign eu_mem_field = eu_mem_field_q;
  assign eu_mem_addr  = eu_mem_addr_q;
  assign eu_mem_data  = eu_mem_data_q;
  assign eu_conf_wr   = eu_conf_wr_q;
  assign eu_conf_data = eu_conf_data_q;
endmodule

// File: tb/tb_treeval_cmd_engine.sv
// tb/tb_treeval_cmd_engine.sv - directed self-checking bench for treeval_cmd_engine
module tb_treeval_cmd_engine;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_msg_rdy;
  logic [63:0] in_msg;
  logic        in_msg_ack;
  logic        out_msg_rdy;
  logic [63:0] out_msg;
  logic        out_msg_ack;
  logic [1:0]  eu_start, eu_mem_wr, eu_conf_wr, eu_done;
  logic [1:0]  eu_mem_field;
  logic [9:0]  eu_mem_addr, eu_mem_data, eu_conf_data;
  logic [19:0] eu_exp;
  logic [5:0]  eu_act;

  int errs = 0;
  int checks = 0;
  int n;
  logic seen;

  treeval_cmd_engine #(
    .N_UNITS(2), .W_ADDR(10), .W_DATA(10), .W_REWARD(10), .W_ACTION(3), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .in_msg_rdy(in_msg_rdy), .in_msg(in_msg), .in_msg_ack(in_msg_ack),
    .out_msg_rdy(out_msg_rdy), .out_msg(out_msg), .out_msg_ack(out_msg_ack),
    .eu_start(eu_start), .eu_mem_wr(eu_mem_wr), .eu_mem_field(eu_mem_field),
    .eu_mem_addr(eu_mem_addr), .eu_mem_data(eu_mem_data),
    .eu_conf_wr(eu_conf_wr), .eu_conf_data(eu_conf_data),
    .eu_done(eu_done), .eu_exp(eu_exp), .eu_act(eu_act)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] mk(input logic [1:0] c, input logic [1:0] s, input logic [3:0] u,
                                     input logic [9:0] a, input logic [9:0] d);
    return {c, s, u, 36'd0, a, d};
  endfunction

  function automatic logic [63:0] rsp(input logic [1:0] t, input logic [3:0] u, input logic [55:0] p);
    return {t, 2'b00, u, p};
  endfunction

  // Presents a message for one cycle, checks ack, and returns at the k+2 sample point.
  task automatic send(input logic [63:0] m);
    in_msg = m; in_msg_rdy = 1'b1;
    @(negedge clk);
    check("accept_ack", {63'd0, in_msg_ack}, 64'd1);
    in_msg_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic take(input string tag, input logic [63:0] expv);
    check({tag, "_rdy"}, {63'd0, out_msg_rdy}, 64'd1);
    check({tag, "_msg"}, out_msg, expv);
    out_msg_ack = 1'b1;
    @(negedge clk);
    out_msg_ack = 1'b0;
    check({tag, "_rdy_drop"}, {63'd0, out_msg_rdy}, 64'd0);
  endtask

  task automatic no_strobes(input string tag);
    check(tag, {58'd0, eu_start, eu_mem_wr, eu_conf_wr}, 64'd0);
  endtask

  initial begin
    rst = 1'b1; in_msg_rdy = 1'b0; in_msg = '0; out_msg_ack = 1'b0;
    eu_done = '0; eu_exp = '0; eu_act = '0;
    repeat (2) @(negedge clk);
    check("reset_outs", {out_msg_rdy, in_msg_ack, eu_start, eu_mem_wr, eu_conf_wr,
                         eu_mem_field, eu_mem_addr, eu_mem_data, eu_conf_data}, 64'd0);
    check("reset_out_msg", out_msg, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Node write to unit 1, field 2
    send(mk(2'd1, 2'd2, 4'd1, 10'd5, 10'h2A));
    check("node_wr", {62'd0, eu_mem_wr}, 64'd2);
    check("node_field", {62'd0, eu_mem_field}, 64'd2);
    check("node_addr", {54'd0, eu_mem_addr}, 64'd5);
    check("node_data", {54'd0, eu_mem_data}, 64'h2A);
    check("node_no_resp", {63'd0, out_msg_rdy}, 64'd0);
    @(negedge clk);
    check("node_wr_pulse", {62'd0, eu_mem_wr}, 64'd0);
    check("node_addr_hold", {54'd0, eu_mem_addr}, 64'd5);

    // Config write unit 0
    send(mk(2'd2, 2'd0, 4'd0, 10'd0, 10'h155));
    check("conf_wr", {62'd0, eu_conf_wr}, 64'd1);
    check("conf_data", {54'd0, eu_conf_data}, 64'h155);

    // Blocking run on unit 0, done 20 cycles after start
    send(mk(2'd0, 2'd0, 4'd0, 10'd0, 10'd0));
    check("run_start", {62'd0, eu_start}, 64'd1);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_msg_rdy) seen = 1'b1;
    end
    check("run_wait_quiet", {63'd0, seen}, 64'd0);
    eu_done = 2'b01; eu_exp[9:0] = 10'h3F5; eu_act[2:0] = 3'd3;
    @(negedge clk);
    eu_done = 2'b00; eu_exp = '0; eu_act = '0;
    check("run_rdy", {63'd0, out_msg_rdy}, 64'd1);
    repeat (3) @(negedge clk);
    take("run_result", rsp(2'd0, 4'd0, 56'h0FF5));
    send(mk(2'd3, 2'd0, 4'd0, 10'd0, 10'd0));
    take("status_after_run", rsp(2'd2, 4'd0, 56'h0));

    // Launch unit 1, then status, fetch, fetch again
    send(mk(2'd0, 2'd1, 4'd1, 10'd0, 10'd0));
    check("launch_start", {62'd0, eu_start}, 64'd2);
    check("launch_no_resp", {63'd0, out_msg_rdy}, 64'd0);
    @(negedge clk);
    eu_done = 2'b10; eu_exp[19:10] = 10'h1A2; eu_act[5:3] = 3'd5;
    @(negedge clk);
    eu_done = 2'b00; eu_exp = 20'hFFFFF; eu_act = 6'h3F;
    send(mk(2'd3, 2'd0, 4'd0, 10'd0, 10'd0));
    take("status_launch", rsp(2'd2, 4'd0, 56'h2));
    send(mk(2'd3, 2'd1, 4'd1, 10'd0, 10'd0));
    take("fetch1", rsp(2'd0, 4'd1, 56'h15A2));
    send(mk(2'd3, 2'd1, 4'd1, 10'd0, 10'd0));
    take("fetch_again", rsp(2'd1, 4'd1, 56'h4));
    eu_exp = '0; eu_act = '0;

    // Error responses
    send(mk(2'd2, 2'd0, 4'd7, 10'd0, 10'd1));
    no_strobes("err_unit_nostrobe");
    take("err_unit", rsp(2'd1, 4'd7, 56'h1));
    send(mk(2'd1, 2'd0, 4'd7, 10'd3, 10'd1));
    no_strobes("err_node_unit_nostrobe");
    take("err_node_unit", rsp(2'd1, 4'd7, 56'h1));
    send(mk(2'd2, 2'd2, 4'd0, 10'd0, 10'd1));
    no_strobes("err_conf_sub_nostrobe");
    take("err_conf_sub", rsp(2'd1, 4'd0, 56'h3));
    send(mk(2'd0, 2'd2, 4'd0, 10'd0, 10'd0));
    no_strobes("err_run_sub_nostrobe");
    take("err_run_sub", rsp(2'd1, 4'd0, 56'h3));
    send(mk(2'd3, 2'd3, 4'd0, 10'd0, 10'd0));
    take("err_query_sub", rsp(2'd1, 4'd0, 56'h3));

    // Blocking run with no done
    send(mk(2'd0, 2'd0, 4'd1, 10'd0, 10'd0));
    check("to_start", {62'd0, eu_start}, 64'd2);
`ifdef TREEVAL_CMD_TIMEOUT_EN
    n = 0;
    while (!out_msg_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", 64'(n), 64'd8);
    take("timeout_err", rsp(2'd1, 4'd1, 56'h2));
`else
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (out_msg_rdy) seen = 1'b1;
    end
    check("no_timeout_wait", {63'd0, seen}, 64'd0);
    eu_done = 2'b10; eu_exp[19:10] = 10'h011; eu_act[5:3] = 3'd1;
    @(negedge clk);
    eu_done = 2'b00; eu_exp = '0; eu_act = '0;
    take("late_done", rsp(2'd0, 4'd1, 56'h0411));
`endif

    // Reset while a response is pending
    send(mk(2'd0, 2'd1, 4'd0, 10'd0, 10'd0));
    eu_done = 2'b01;
    @(negedge clk);
    eu_done = 2'b00;
    send(mk(2'd3, 2'd0, 4'd0, 10'd0, 10'd0));
    check("pre_reset_status", out_msg, rsp(2'd2, 4'd0, 56'h1));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_rdy", {63'd0, out_msg_rdy}, 64'd0);
    no_strobes("rst_nostrobe");
    send(mk(2'd3, 2'd0, 4'd0, 10'd0, 10'd0));
    take("post_reset_status", rsp(2'd2, 4'd0, 56'h0));
    send(mk(2'd1, 2'd3, 4'd0, 10'd9, 10'd7));
    check("post_reset_node", {52'd0, eu_mem_wr, eu_mem_field, eu_mem_data[7:0]}, {52'd0, 2'b01, 2'd3, 8'd7});

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
